// File: rtl/hazard_scoreboard_pkg.sv
// Shared core package for the hazard scoreboard.
// Holds the long-latency unit indices and the per-unit scoreboard entry type.
// The entry tag is sized for the widest supported register address (SB_TAG_W).
// Narrower register files zero-extend into it.
package hazard_scoreboard_pkg;

   localparam int unsigned SB_TAG_W = 8;

   localparam int unsigned UNIT_LSU = 0;
   localparam int unsigned UNIT_DIV = 1;
   localparam int unsigned UNIT_CSR = 2;

   typedef struct packed {
      logic                busy;
      logic [SB_TAG_W-1:0] tag;
   } type_sb_entry_s;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard signal bundle.
// master: pipeline side. It drives EXE/WRB/CSR requests and receives the stall, forward and redirect controls.
// slave : scoreboard side, which is the mirror image of master.
interface hazard_scoreboard_if #(
   parameter int unsigned NUM_UNITS = 3,
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned CNT_W     = 16
);
   logic [REG_AW-1:0]    exe_rs1_addr;
   logic [REG_AW-1:0]    exe_rs2_addr;
   logic                 exe_use_rs1;
   logic                 exe_use_rs2;
   logic [NUM_UNITS-1:0] exe_issue_req;
   logic [REG_AW-1:0]    exe_rd_addr;
   logic                 exe_new_pc_req;
   logic [NUM_UNITS-1:0] unit_ack;
   logic [REG_AW-1:0]    wrb_rd_addr;
   logic                 wrb_rd_wr_req;
   logic                 csr_new_pc_req;
   logic                 csr_wfi_req;

   logic                 fwd_wrb_rs1;
   logic                 fwd_wrb_rs2;
   logic                 pipe_stall;
   logic [NUM_UNITS-1:0] issue_accept;
   logic                 new_pc_exe;
   logic                 new_pc_csr;
   logic                 pipe_flush;
   logic                 unit_flush;
   logic                 stall_ff;
   logic [CNT_W-1:0]     stall_cycles;

   modport master (
      output exe_rs1_addr, exe_rs2_addr, exe_use_rs1, exe_use_rs2,
             exe_issue_req, exe_rd_addr, exe_new_pc_req, unit_ack,
             wrb_rd_addr, wrb_rd_wr_req, csr_new_pc_req, csr_wfi_req,
      input  fwd_wrb_rs1, fwd_wrb_rs2, pipe_stall, issue_accept,
             new_pc_exe, new_pc_csr, pipe_flush, unit_flush,
             stall_ff, stall_cycles
   );

   modport slave (
      input  exe_rs1_addr, exe_rs2_addr, exe_use_rs1, exe_use_rs2,
             exe_issue_req, exe_rd_addr, exe_new_pc_req, unit_ack,
             wrb_rd_addr, wrb_rd_wr_req, csr_new_pc_req, csr_wfi_req,
      output fwd_wrb_rs1, fwd_wrb_rs2, pipe_stall, issue_accept,
             new_pc_exe, new_pc_csr, pipe_flush, unit_flush,
             stall_ff, stall_cycles
   );

endinterface

// File: rtl/hazard_scoreboard_sb_unit_slot.sv
// One long-latency unit's scoreboard slot. It has two states:
//   busy = 0 : IDLE, no write is pending.
//   busy = 1 : PEND, a write to the register in tag is pending.
// Ports:
//   clk, rst                 : clock and asynchronous active-high reset
//   issue_req                : EXE requests an issue to this unit (before gating)
//   issue_any                : EXE is issuing to any unit (WAW check)
//   issue_accept             : the issue to this unit is accepted this cycle
//   ack                      : completion pulse from this unit
//   unit_flush               : flush of the long-latency units
//   rd_addr                  : destination register of the issuing op
//   rs1/rs2_addr, use_rs1/2  : EXE source operands
//   raw_hit/waw_hit/busy_hit : this slot's hazard contributions (combinational)
module sb_unit_slot
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned REG_AW    = 5,
   parameter bit          FLUSHABLE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_req,
   input  logic              issue_any,
   input  logic              issue_accept,
   input  logic              ack,
   input  logic              unit_flush,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   input  logic              use_rs1,
   input  logic              use_rs2,
   output logic              raw_hit,
   output logic              waw_hit,
   output logic              busy_hit
);

   type_sb_entry_s entry_q;
   type_sb_entry_s entry_d;
   logic           live;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   // Next state. Flush wins. An accepted issue overrides a same-cycle ack.
   // An rd of x0 never marks the slot busy.
   always_comb begin
      entry_d = entry_q;
      if (unit_flush && FLUSHABLE) begin
         entry_d.busy = 1'b0;
      end else if (issue_accept) begin
         entry_d.busy = (rd_addr != '0);
         entry_d.tag  = SB_TAG_W'(rd_addr);
      end else if (ack) begin
         entry_d.busy = 1'b0;
      end
   end

   // Hazard compare. A slot that acks this cycle no longer blocks anything.
   always_comb begin
      live     = entry_q.busy & ~ack;
      raw_hit  = live & ((use_rs1 & (rs1_addr != '0) & (SB_TAG_W'(rs1_addr) == entry_q.tag)) |
                         (use_rs2 & (rs2_addr != '0) & (SB_TAG_W'(rs2_addr) == entry_q.tag)));
      waw_hit  = live & issue_any & (rd_addr != '0) & (SB_TAG_W'(rd_addr) == entry_q.tag);
      busy_hit = live & issue_req;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the long-latency units (LSU, DIV, CSR).
// It tracks the pending destination register of each unit.
// It stalls EXE on RAW, WAW and busy-unit hazards.
// It gates branch redirects and generates the pipeline and unit flushes.
// It also counts stalled cycles.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   sb       : slave side of hazard_scoreboard_if
//              (EXE/WRB/CSR requests in; stall, forward, redirect and flush controls out)
// Note: REG_AW must not exceed SB_TAG_W.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned          NUM_UNITS  = 3,
   parameter int unsigned          REG_AW     = 5,
   parameter logic [NUM_UNITS-1:0] FLUSH_MASK = NUM_UNITS'(3'b011),
   parameter int unsigned          CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave sb
);

   logic [NUM_UNITS-1:0] raw_hit;
   logic [NUM_UNITS-1:0] waw_hit;
   logic [NUM_UNITS-1:0] busy_hit;
   logic [NUM_UNITS-1:0] accept_c;
   logic                 issue_any_c;
   logic                 stall_c;
   logic                 new_pc_exe_c;
   logic                 unit_flush_c;
   logic                 pipe_flush_c;
   logic                 stall_ff_q;
   logic [CNT_W-1:0]     stall_cycles_q;

   assign issue_any_c = |sb.exe_issue_req;

   for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
      sb_unit_slot #(
         .REG_AW    (REG_AW),
         .FLUSHABLE (FLUSH_MASK[i])
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .issue_req    (sb.exe_issue_req[i]),
         .issue_any    (issue_any_c),
         .issue_accept (accept_c[i]),
         .ack          (sb.unit_ack[i]),
         .unit_flush   (unit_flush_c),
         .rd_addr      (sb.exe_rd_addr),
         .rs1_addr     (sb.exe_rs1_addr),
         .rs2_addr     (sb.exe_rs2_addr),
         .use_rs1      (sb.exe_use_rs1),
         .use_rs2      (sb.exe_use_rs2),
         .raw_hit      (raw_hit[i]),
         .waw_hit      (waw_hit[i]),
         .busy_hit     (busy_hit[i])
      );
   end

   // Stall, redirect and flush decode. Everything is same-cycle.
   always_comb begin
      stall_c      = (|raw_hit) | (|waw_hit) | (|busy_hit);
      new_pc_exe_c = sb.exe_new_pc_req & ~stall_c & ~sb.csr_new_pc_req;
      unit_flush_c = sb.csr_new_pc_req | sb.csr_wfi_req;
      pipe_flush_c = new_pc_exe_c | unit_flush_c;
      accept_c     = sb.exe_issue_req & {NUM_UNITS{~(stall_c | pipe_flush_c)}};
   end

   // Registered stall copy and saturating stall-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_ff_q     <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         stall_ff_q <= stall_c;
         if (stall_c && !(&stall_cycles_q)) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
         end
      end
   end

   assign sb.fwd_wrb_rs1  = (sb.exe_rs1_addr == sb.wrb_rd_addr) & sb.wrb_rd_wr_req &
                            (sb.exe_rs1_addr != '0);
   assign sb.fwd_wrb_rs2  = (sb.exe_rs2_addr == sb.wrb_rd_addr) & sb.wrb_rd_wr_req &
                            (sb.exe_rs2_addr != '0);
   assign sb.pipe_stall   = stall_c;
   assign sb.issue_accept = accept_c;
   assign sb.new_pc_exe   = new_pc_exe_c;
   assign sb.new_pc_csr   = sb.csr_new_pc_req;
   assign sb.pipe_flush   = pipe_flush_c;
   assign sb.unit_flush   = unit_flush_c;
   assign sb.stall_ff     = stall_ff_q;
   assign sb.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. It runs directed scenarios and then a randomized run.
// The randomized run is checked against a per-unit pending-register model.
module tb_hazard_scoreboard;

   localparam int unsigned NU     = 3;
   localparam int unsigned AW     = 5;
   localparam int unsigned CW     = 4;
   localparam logic [2:0]  FMASK  = 3'b011;
   localparam int          CNTMAX = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   hazard_scoreboard_if #(.NUM_UNITS(NU), .REG_AW(AW), .CNT_W(CW)) sbi ();

   hazard_scoreboard #(
      .NUM_UNITS  (NU),
      .REG_AW     (AW),
      .FLUSH_MASK (FMASK),
      .CNT_W      (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sbi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue requests must be one-hot or idle
   always @(negedge clk) begin
      if (!rst) begin
         assert ($onehot0(sbi.exe_issue_req))
         else $error("illegal multi-hot exe_issue_req %b", sbi.exe_issue_req);
      end
   end

   // Reference model: which register each unit still owes, plus counter state
   bit          m_busy [NU];
   int          m_tag  [NU];
   int          m_cnt;
   bit          m_sff;
   bit          e_stall, e_npe, e_flush, e_uflush, e_fwd1, e_fwd2;
   logic [NU-1:0] e_acc;

   task automatic model_reset();
      for (int u = 0; u < NU; u++) begin
         m_busy[u] = 1'b0;
         m_tag[u]  = 0;
      end
      m_cnt = 0;
      m_sff = 1'b0;
   endtask

   task automatic model_comb();
      bit raw, waw, bsy;
      int rs1, rs2, rd;
      raw = 0; waw = 0; bsy = 0;
      rs1 = int'(sbi.exe_rs1_addr);
      rs2 = int'(sbi.exe_rs2_addr);
      rd  = int'(sbi.exe_rd_addr);
      for (int u = 0; u < NU; u++) begin
         if (m_busy[u] && !sbi.unit_ack[u]) begin
            if (sbi.exe_use_rs1 && rs1 != 0 && rs1 == m_tag[u]) raw = 1;
            if (sbi.exe_use_rs2 && rs2 != 0 && rs2 == m_tag[u]) raw = 1;
            if (sbi.exe_issue_req != 0 && rd != 0 && rd == m_tag[u]) waw = 1;
            if (sbi.exe_issue_req[u]) bsy = 1;
         end
      end
      e_stall  = raw || waw || bsy;
      e_npe    = sbi.exe_new_pc_req && !e_stall && !sbi.csr_new_pc_req;
      e_uflush = sbi.csr_new_pc_req || sbi.csr_wfi_req;
      e_flush  = e_npe || e_uflush;
      e_acc    = (e_stall || e_flush) ? '0 : sbi.exe_issue_req;
      e_fwd1   = sbi.wrb_rd_wr_req && rs1 != 0 && rs1 == int'(sbi.wrb_rd_addr);
      e_fwd2   = sbi.wrb_rd_wr_req && rs2 != 0 && rs2 == int'(sbi.wrb_rd_addr);
   endtask

   task automatic model_step();
      for (int u = 0; u < NU; u++) begin
         if (e_uflush && FMASK[u]) m_busy[u] = 1'b0;
         else if (e_acc[u]) begin
            m_busy[u] = (sbi.exe_rd_addr != 0);
            m_tag[u]  = int'(sbi.exe_rd_addr);
         end else if (sbi.unit_ack[u]) m_busy[u] = 1'b0;
      end
      m_sff = e_stall;
      if (e_stall && m_cnt < CNTMAX) m_cnt++;
   endtask

   task automatic set_in(input int rs1, input int rs2, input int u1, input int u2,
                         input int iss, input int rd, input int npc, input int ack,
                         input int wrb, input int wrw, input int cpc, input int wfi);
      sbi.exe_rs1_addr   = AW'(rs1);
      sbi.exe_rs2_addr   = AW'(rs2);
      sbi.exe_use_rs1    = 1'(u1);
      sbi.exe_use_rs2    = 1'(u2);
      sbi.exe_issue_req  = NU'(iss);
      sbi.exe_rd_addr    = AW'(rd);
      sbi.exe_new_pc_req = 1'(npc);
      sbi.unit_ack       = NU'(ack);
      sbi.wrb_rd_addr    = AW'(wrb);
      sbi.wrb_rd_wr_req  = 1'(wrw);
      sbi.csr_new_pc_req = 1'(cpc);
      sbi.csr_wfi_req    = 1'(wfi);
      #1;
      model_comb();
   endtask

   task automatic idle_in();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(7, 0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
      model_reset();
      total++; if (sbi.stall_ff !== 1'b0) begin bad++; $display("FAIL rst_stall_ff got=%b exp=0", sbi.stall_ff); end
      total++; if (sbi.stall_cycles !== '0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", sbi.stall_cycles); end
      total++; if (sbi.fwd_wrb_rs1 !== 1'b1) begin bad++; $display("FAIL rst_fwd1 got=%b exp=1", sbi.fwd_wrb_rs1); end
      @(posedge clk); #1;
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", sbi.pipe_stall); end
      rst = 1'b0;
      idle_in();
   endtask

   task automatic test_load_use();
      set_in(0, 0, 0, 0, 3'b001, 5, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.issue_accept !== 3'b001) begin bad++; $display("FAIL lu_accept got=%b exp=001", sbi.issue_accept); end
      tick();
      set_in(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         total++; if (sbi.pipe_stall !== 1'b1) begin bad++; $display("FAIL lu_stall[%0d] got=%b exp=1", k, sbi.pipe_stall); end
         tick();
      end
      total++; if (sbi.stall_ff !== 1'b1) begin bad++; $display("FAIL lu_stall_ff got=%b exp=1", sbi.stall_ff); end
      set_in(5, 0, 1, 0, 0, 0, 0, 3'b001, 5, 1, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL lu_ack_stall got=%b exp=0", sbi.pipe_stall); end
      total++; if (sbi.fwd_wrb_rs1 !== 1'b1) begin bad++; $display("FAIL lu_fwd1 got=%b exp=1", sbi.fwd_wrb_rs1); end
      tick();
      total++; if (sbi.stall_ff !== 1'b0) begin bad++; $display("FAIL lu_stall_ff_clr got=%b exp=0", sbi.stall_ff); end
      set_in(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL lu_after got=%b exp=0", sbi.pipe_stall); end
      idle_in();
   endtask

   task automatic test_busy_unit();
      set_in(0, 0, 0, 0, 3'b010, 7, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 3'b010, 9, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b1) begin bad++; $display("FAIL busy_stall got=%b exp=1", sbi.pipe_stall); end
      total++; if (sbi.issue_accept !== 3'b000) begin bad++; $display("FAIL busy_accept got=%b exp=000", sbi.issue_accept); end
      tick();
      set_in(0, 0, 0, 0, 3'b010, 9, 0, 3'b010, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL busy_reiss_stall got=%b exp=0", sbi.pipe_stall); end
      total++; if (sbi.issue_accept !== 3'b010) begin bad++; $display("FAIL busy_reiss_accept got=%b exp=010", sbi.issue_accept); end
      tick();
      set_in(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b1) begin bad++; $display("FAIL busy_newtag got=%b exp=1", sbi.pipe_stall); end
      set_in(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL busy_oldtag got=%b exp=0", sbi.pipe_stall); end
      set_in(0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0);
      tick();
      idle_in();
   endtask

   task automatic test_waw();
      set_in(0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 3'b100, 3, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         total++; if (sbi.pipe_stall !== 1'b1) begin bad++; $display("FAIL waw_stall[%0d] got=%b exp=1", k, sbi.pipe_stall); end
         total++; if (sbi.issue_accept !== 3'b000) begin bad++; $display("FAIL waw_accept[%0d] got=%b exp=000", k, sbi.issue_accept); end
         tick();
      end
      set_in(0, 0, 0, 0, 3'b100, 3, 0, 3'b001, 0, 0, 0, 0);
      total++; if (sbi.issue_accept !== 3'b100) begin bad++; $display("FAIL waw_ack_accept got=%b exp=100", sbi.issue_accept); end
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
      tick();
      idle_in();
   endtask

   task automatic test_flush();
      set_in(0, 0, 0, 0, 3'b001, 4, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 3'b100, 6, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      total++; if (sbi.pipe_flush !== 1'b1) begin bad++; $display("FAIL fl_pipe_flush got=%b exp=1", sbi.pipe_flush); end
      total++; if (sbi.new_pc_exe !== 1'b0) begin bad++; $display("FAIL fl_new_pc_exe got=%b exp=0", sbi.new_pc_exe); end
      total++; if (sbi.new_pc_csr !== 1'b1) begin bad++; $display("FAIL fl_new_pc_csr got=%b exp=1", sbi.new_pc_csr); end
      total++; if (sbi.unit_flush !== 1'b1) begin bad++; $display("FAIL fl_unit_flush got=%b exp=1", sbi.unit_flush); end
      tick();
      set_in(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL fl_lsu_idle got=%b exp=0", sbi.pipe_stall); end
      set_in(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b1) begin bad++; $display("FAIL fl_csr_pend got=%b exp=1", sbi.pipe_stall); end
      set_in(6, 0, 1, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL fl_csr_ack got=%b exp=0", sbi.pipe_stall); end
      tick();
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      total++; if (sbi.new_pc_exe !== 1'b1 || sbi.unit_flush !== 1'b0) begin
         bad++; $display("FAIL fl_exe_redirect got=%b/%b exp=1/0", sbi.new_pc_exe, sbi.unit_flush);
      end
      idle_in();
   endtask

   task automatic test_x0();
      set_in(0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.issue_accept !== 3'b001) begin bad++; $display("FAIL x0_accept got=%b exp=001", sbi.issue_accept); end
      tick();
      set_in(0, 0, 1, 1, 3'b001, 0, 0, 0, 0, 1, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", sbi.pipe_stall); end
      total++; if (sbi.fwd_wrb_rs1 !== 1'b0 || sbi.fwd_wrb_rs2 !== 1'b0) begin
         bad++; $display("FAIL x0_fwd got=%b/%b exp=0/0", sbi.fwd_wrb_rs1, sbi.fwd_wrb_rs2);
      end
      total++; if (sbi.issue_accept !== 3'b001) begin bad++; $display("FAIL x0_reissue got=%b exp=001", sbi.issue_accept); end
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
      tick();
      idle_in();
   endtask

   task automatic test_counter();
      rst = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      set_in(0, 0, 0, 0, 3'b001, 10, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         total++; if (int'(sbi.stall_cycles) != ((k < CNTMAX) ? k : CNTMAX)) begin
            bad++; $display("FAIL cnt[%0d] got=%0d exp=%0d", k, sbi.stall_cycles, (k < CNTMAX) ? k : CNTMAX);
         end
      end
      rst = 1'b1;
      #1;
      model_reset();
      total++; if (sbi.stall_cycles !== '0 || sbi.stall_ff !== 1'b0) begin
         bad++; $display("FAIL cnt_rst got=%0d/%b exp=0/0", sbi.stall_cycles, sbi.stall_ff);
      end
      total++; if (sbi.pipe_stall !== 1'b0) begin bad++; $display("FAIL cnt_rst_drop got=%b exp=0", sbi.pipe_stall); end
      @(negedge clk);
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
      tick();
      set_in(10, 0, 1, 0, 3'b001, 12, 0, 0, 0, 0, 0, 0);
      total++; if (sbi.pipe_stall !== 1'b0 || sbi.issue_accept !== 3'b001) begin
         bad++; $display("FAIL late_ack got=%b/%b exp=0/001", sbi.pipe_stall, sbi.issue_accept);
      end
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
      tick();
      idle_in();
   endtask

   task automatic test_random();
      int iss, ack;
      for (int c = 0; c < 400; c++) begin
         iss = ($urandom_range(0, 1) == 0) ? (1 << $urandom_range(0, NU - 1)) : 0;
         ack = 0;
         for (int u = 0; u < NU; u++) if ($urandom_range(0, 3) == 0) ack |= (1 << u);
         set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                iss, $urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 1 : 0, ack,
                $urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 19) == 0) ? 1 : 0,
                ($urandom_range(0, 19) == 0) ? 1 : 0);
         total++; if (sbi.pipe_stall !== e_stall) begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", c, sbi.pipe_stall, e_stall); end
         total++; if (sbi.issue_accept !== e_acc) begin bad++; $display("FAIL rnd_accept[%0d] got=%b exp=%b", c, sbi.issue_accept, e_acc); end
         total++; if (sbi.new_pc_exe !== e_npe || sbi.new_pc_csr !== sbi.csr_new_pc_req) begin
            bad++; $display("FAIL rnd_new_pc[%0d] got=%b/%b exp=%b/%b", c, sbi.new_pc_exe, sbi.new_pc_csr, e_npe, sbi.csr_new_pc_req);
         end
         total++; if (sbi.pipe_flush !== e_flush || sbi.unit_flush !== e_uflush) begin
            bad++; $display("FAIL rnd_flush[%0d] got=%b/%b exp=%b/%b", c, sbi.pipe_flush, sbi.unit_flush, e_flush, e_uflush);
         end
         total++; if (sbi.fwd_wrb_rs1 !== e_fwd1 || sbi.fwd_wrb_rs2 !== e_fwd2) begin
            bad++; $display("FAIL rnd_fwd[%0d] got=%b/%b exp=%b/%b", c, sbi.fwd_wrb_rs1, sbi.fwd_wrb_rs2, e_fwd1, e_fwd2);
         end
         tick();
         total++; if (sbi.stall_ff !== m_sff || int'(sbi.stall_cycles) != m_cnt) begin
            bad++; $display("FAIL rnd_regs[%0d] got=%b/%0d exp=%b/%0d", c, sbi.stall_ff, sbi.stall_cycles, m_sff, m_cnt);
         end
      end
      idle_in();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_load_use();
      test_busy_unit();
      test_waw();
      test_flush();
      test_x0();
      test_counter();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
